e1ofn_channel_sink: RTL
=======================

Name: e1ofn_channel_sink

Overview:
- Clocked receiver for a four-phase, delay-insensitive e1ofN channel.
- DIGITS digits, each one-hot over RAILS rails, with an enable/acknowledge wire.
- Synchronises the rails, detects completion and neutrality, and drives the enable handshake.
- Converts each token to binary and buffers it in a DEPTH-entry FIFO with a valid/ready output.
- Successor to the fixed 1-digit dual-rail sink. Sits between asynchronous (prsim-driven or delay-line) channels and the synchronous verilog side.

Parameters:
- RAILS, 2, rails per digit (N of 1ofN); legal values ≥2.
- DIGITS, 1, digits per token.
- DEPTH, 4, FIFO entries; legal values ≥1.
- SYNC_STAGES, 2, flops in each rail synchroniser; legal values ≥2.
- EN_ACTIVE_LOW, 0, 0: ch_e high means "ready"; 1: ch_e is an active-high acknowledge, low means "ready".
- Derived: LOGR = $clog2(RAILS); DW = DIGITS*LOGR.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- ch_d, in, DIGITS*RAILS, rails; digit k occupies [k*RAILS +: RAILS]; asynchronous.
- ch_e, out, 1, channel enable/ack, registered.
- out_data, out, DW, binary token; digit k occupies [k*LOGR +: LOGR]; rail index = value.
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, consumer accepts head when out_valid && out_ready at posedge.
- count, out, $clog2(DEPTH+1), FIFO occupancy.
- proto_err, out, 1, sticky protocol-error flag.
- err_clear, in, 1, clears proto_err.

Behaviour:
- Reset (synchronous, active-high, on any cycle including mid-handshake):
  - synchronisers cleared, FSM to WAIT_DATA, FIFO emptied.
  - count=0, out_valid=0, out_data=0, proto_err=0.
  - ch_e driven to its "ready" level: 1 if EN_ACTIVE_LOW=0, else 0.
- Synchroniser: each rail passes SYNC_STAGES flops. All decode uses synchronised rails (sd) only.
- Per-digit decode:
  - valid = exactly one rail high.
  - neutral = all rails low.
  - illegal = two or more rails high.
- Token complete = all digits valid. Token neutral = all digits neutral. Bad = any digit illegal.
- FSM states:
  - WAIT_DATA (ch_e at "ready"):
    - bad → set proto_err, drive ch_e to "ack", go to WAIT_NEUTRAL; no FIFO write.
    - complete && fifo_can_write → write token, drive ch_e to "ack", go to WAIT_NEUTRAL.
    - complete && FIFO full → hold in WAIT_DATA, ch_e unchanged (backpressure).
    - otherwise stay.
  - WAIT_NEUTRAL (ch_e at "ack"):
    - token neutral → drive ch_e to "ready", go to WAIT_DATA.
    - illegal codes seen here also set proto_err.
- fifo_can_write = count<DEPTH, or count==DEPTH with a pop in the same cycle (simultaneous push+pop on full is legal; count unchanged).
- Latency:
  - rails stable before posedge k → FIFO write and ch_e toggle at posedge k+SYNC_STAGES.
  - out_valid high after that same edge if the FIFO was empty (first-word fall-through).
- FIFO ordering and pointers:
  - strict FIFO order; pointers wrap modulo DEPTH.
  - push+pop on empty: the token is written and out_valid rises; count=1.
- out_data holds the head value while out_valid && !out_ready.
- out_data is 0 when empty.
- proto_err:
  - clears on err_clear.
  - if err_clear and a new error occur in the same cycle, the error wins (flag stays 1).
- Partial-arrival digits (some valid, some neutral) are neither complete nor bad: wait.

Decomposition:
- Package e1ofn_pkg holds:
  - state enum {WAIT_DATA, WAIT_NEUTRAL};
  - function onehot_to_bin(RAILS-wide vector) → LOGR;
  - function rail_count for illegal detection.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, fall-through head). The synchroniser stays inline as a generate loop.

Test Plan:
- Reset and defaults: RAILS=2, DIGITS=1, EN_ACTIVE_LOW=0. Assert reset 3 cycles → ch_e=1, out_valid=0, count=0, proto_err=0.
- Source loop 0,1,1,0: ch_d driven by a four-phase source honouring ch_e, out_ready=1 → out_data sequence 0,1,1,0. ch_e falls SYNC_STAGES cycles after each rail rise.
- Backpressure: DEPTH=4, out_ready=0, 6 tokens offered → count saturates at 4, ch_e stays high on the 5th token. Set out_ready=1 → the remaining 2 are delivered in order.
- Multi-digit: RAILS=4, DIGITS=2, token rails {digit1=rail 3, digit0=rail 2} arriving 5 cycles apart → single write, out_data=8'h0E... wait, with LOGR=2 the width is 4: out_data=4'b1110.
- Protocol error: ch_d=2'b11 → proto_err=1, no FIFO write, ch_e drops. Neutral → ch_e=1. err_clear pulse → proto_err=0.
- Reset mid-handshake: ch_e=0 in WAIT_NEUTRAL and count=2, then reset → ch_e=1, count=0 next cycle, no spurious write once rails go neutral. EN_ACTIVE_LOW=1 variant shows inverted ch_e levels.

Source files
------------

// File: rtl/e1ofn_pkg.sv
// Shared types and helpers for the e1ofN channel sink.
package e1ofn_pkg;

    // Widest digit the helpers accept; callers zero-extend narrower digits.
    localparam int MAX_RAILS = 64;

    typedef enum logic {
        WAIT_DATA    = 1'b0,
        WAIT_NEUTRAL = 1'b1
    } state_t;

    // Index of the (single) high rail; OR of indices, so only meaningful when one-hot.
    function automatic logic [5:0] onehot_to_bin(input logic [MAX_RAILS-1:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < MAX_RAILS; i++) begin
            if (v[i]) r = r | 6'(i);
        end
        return r;
    endfunction

    // Number of high rails in a digit.
    function automatic logic [6:0] rail_count(input logic [MAX_RAILS-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAX_RAILS; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/e1ofn_channel_sink_fifo.sv
// Fall-through FIFO: head is visible on the cycle after the write, zero when empty.
module sync_fifo
    import e1ofn_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // Push on full is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap at DEPTH, not at a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/e1ofn_channel_sink.sv
// Clocked sink for a four-phase e1ofN channel: synchronise rails, decode the
// token, run the enable handshake and queue decoded tokens in a FIFO.
module e1ofn_channel_sink
    import e1ofn_pkg::*;
#(
    parameter  int RAILS         = 2,
    parameter  int DIGITS        = 1,
    parameter  int DEPTH         = 4,
    parameter  int SYNC_STAGES   = 2,
    parameter  int EN_ACTIVE_LOW = 0,
    localparam int LOGR          = $clog2(RAILS),
    localparam int DW            = DIGITS * LOGR,
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIGITS*RAILS-1:0]  ch_d,
    output logic                     ch_e,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            count,
    output logic                     proto_err,
    input  logic                     err_clear
);

    localparam logic EN_READY = (EN_ACTIVE_LOW == 0);
    localparam logic EN_ACK   = ~EN_READY;

    logic [SYNC_STAGES-1:0][DIGITS*RAILS-1:0] sync_q;
    logic [DIGITS*RAILS-1:0]                  sd;
    logic [DIGITS-1:0]                        dig_valid, dig_neutral, dig_illegal;
    logic [DW-1:0]                            tok;
    logic                                     complete, neutral, bad;
    logic                                     full, empty, push, pop, can_write;
    state_t                                   state;

    // Rail synchroniser chain; everything downstream sees only sd.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= ch_d;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sd = sync_q[SYNC_STAGES-1];

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        logic [MAX_RAILS-1:0] ext;
        // Zero-extend the digit to the helper width.
        always_comb begin
            ext = '0;
            ext[RAILS-1:0] = sd[k*RAILS +: RAILS];
        end
        assign dig_valid[k]          = (rail_count(ext) == 7'd1);
        assign dig_neutral[k]        = (rail_count(ext) == 7'd0);
        assign dig_illegal[k]        = (rail_count(ext) >= 7'd2);
        assign tok[k*LOGR +: LOGR]   = LOGR'(onehot_to_bin(ext));
    end

    assign complete  = &dig_valid;
    assign neutral   = &dig_neutral;
    assign bad       = |dig_illegal;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign can_write = !full || pop;
    assign push      = (state == WAIT_DATA) && !bad && complete && can_write;

    // Handshake FSM with registered enable; errors are sticky and win over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_DATA;
            ch_e      <= EN_READY;
            proto_err <= 1'b0;
        end else begin
            if (bad)            proto_err <= 1'b1;
            else if (err_clear) proto_err <= 1'b0;
            case (state)
                WAIT_DATA: begin
                    if (bad || (complete && can_write)) begin
                        ch_e  <= EN_ACK;
                        state <= WAIT_NEUTRAL;
                    end
                end
                WAIT_NEUTRAL: begin
                    if (neutral) begin
                        ch_e  <= EN_READY;
                        state <= WAIT_DATA;
                    end
                end
                default: state <= WAIT_DATA;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (tok),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (out_data)
    );

endmodule
